mdu_iter: RTL

Parametrised multi-cycle multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) beside the combinational execute stage. Started by the execute stage on an R-type instruction with func7 = 7'b0000001; holds the pipeline through ctrl while computing, then writes the result back to regs with a one-cycle write-enable pulse. Width and multiplier style are parameters.

---
 rtl/mdu_pkg.sv | 31 +++
 rtl/mdu_iter_if.sv | 26 ++
 rtl/mdu_iter_div_core.sv | 48 ++++
 rtl/mdu_iter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package mdu_pkg;

  localparam logic [6:0] FUNC7_M = 7'b0000001;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } state_t;

  // MUL only needs the low half, which is sign-agnostic, so it runs unsigned.
  function automatic logic op1_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op2_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Request/write-back bundle between the execute stage and the multiply/divide unit.
interface mdu_iter_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] op1_i;
  logic [XLEN-1:0] op2_i;
  logic [4:0]      rd_addr_i;
  logic            flush_i;
  logic            hold_flag_o;
  logic            busy_o;
  logic [XLEN-1:0] rd_data_o;
  logic [4:0]      rd_addr_o;
  logic            rd_wen_o;

  modport master (
    output start_i, op_i, op1_i, op2_i, rd_addr_i, flush_i,
    input  hold_flag_o, busy_o, rd_data_o, rd_addr_o, rd_wen_o
  );

  modport slave (
    input  start_i, op_i, op1_i, op2_i, rd_addr_i, flush_i,
    output hold_flag_o, busy_o, rd_data_o, rd_addr_o, rd_wen_o
  );
endinterface

// File: rtl/mdu_iter_div_core.sv
// Restoring radix-2 divider datapath on unsigned operands, one quotient bit per step.
module div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN-1:0] quot_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] div_q;
  logic [XLEN:0]   shifted;
  logic            ge;
  logic [XLEN-1:0] rem_next;

  // The partial remainder needs XLEN+1 bits only transiently; once the
  // divisor is subtracted the result always fits back into XLEN bits.
  always_comb begin
    shifted  = {rem_q, quot_q[XLEN-1]};
    ge       = (shifted >= {1'b0, div_q});
    rem_next = ge ? (shifted[XLEN-1:0] - div_q) : shifted[XLEN-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quot_q <= '0;
      rem_q  <= '0;
      div_q  <= '0;
    end else if (load) begin
      quot_q <= dividend;
      rem_q  <= '0;
      div_q  <= divisor;
    end else if (step) begin
      rem_q  <= rem_next;
      quot_q <= {quot_q[XLEN-2:0], ge};
    end
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mdu_iter.sv
// Multi-cycle RV32M multiply/divide unit: stalls the pipeline while computing,
// then writes back with a single-cycle write-enable pulse.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int MUL_ITERATIVE = 0
) (
  input logic        clk,
  input logic        rst_n,
  mdu_iter_if.slave  bus
);

  localparam int CW = $clog2(XLEN);

  state_t state_q, state_d;

  logic [2:0]        op_q;
  logic [4:0]        rd_addr_q;
  logic [XLEN-1:0]   abs1_q, abs2_q;
  logic              sign1_q, sign2_q;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] prod_q;
  logic [XLEN-1:0]   rd_data_q;
  logic [4:0]        rd_addr_out_q;
  logic              rd_wen_q;

  logic              sign1_in, sign2_in;
  logic [XLEN-1:0]   abs1_in, abs2_in;
  logic              div_zero, div_ovf, fast_path;
  logic [XLEN-1:0]   fast_data;
  logic              accept, step, fix, fast;
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   quotient, remainder;
  logic              neg_res;
  logic [XLEN-1:0]   div_res, div_fixed, fix_data;
  logic [2*XLEN-1:0] prod_fixed;

  always_comb begin
    sign1_in  = op1_signed(bus.op_i) & bus.op1_i[XLEN-1];
    sign2_in  = op2_signed(bus.op_i) & bus.op2_i[XLEN-1];
    abs1_in   = sign1_in ? -bus.op1_i : bus.op1_i;
    abs2_in   = sign2_in ? -bus.op2_i : bus.op2_i;
    div_zero  = (bus.op2_i == '0);
    div_ovf   = (bus.op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op2_i == '1);
    fast_path = bus.op_i[2] & (div_zero | (div_ovf & ~bus.op_i[0]));
    // op_i[1] distinguishes REM/REMU from DIV/DIVU
    if (div_zero) fast_data = bus.op_i[1] ? bus.op1_i : '1;
    else          fast_data = bus.op_i[1] ? '0 : bus.op1_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    fix     = 1'b0;
    fast    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i && !bus.flush_i) begin
          if (fast_path) begin
            fast    = 1'b1;
            state_d = ST_DONE;
          end else begin
            accept  = 1'b1;
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (bus.flush_i) begin
          state_d = ST_IDLE;
        end else begin
          step = 1'b1;
          if ((!op_q[2] && MUL_ITERATIVE == 0) || cnt_q == '0) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (bus.flush_i) begin
          state_d = ST_IDLE;
        end else begin
          fix     = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Shift-add step: add the multiplicand into the upper half, then shift right.
  assign mul_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, abs1_q} : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      rd_addr_q <= '0;
      abs1_q    <= '0;
      abs2_q    <= '0;
      sign1_q   <= 1'b0;
      sign2_q   <= 1'b0;
      cnt_q     <= '0;
      prod_q    <= '0;
    end else if (accept) begin
      op_q      <= bus.op_i;
      rd_addr_q <= bus.rd_addr_i;
      abs1_q    <= abs1_in;
      abs2_q    <= abs2_in;
      sign1_q   <= sign1_in;
      sign2_q   <= sign2_in;
      cnt_q     <= CW'(XLEN-1);
      prod_q    <= {{XLEN{1'b0}}, abs2_in};
    end else if (step) begin
      cnt_q <= cnt_q - CW'(1);
      if (!op_q[2]) begin
        if (MUL_ITERATIVE != 0)
          prod_q <= {mul_sum, prod_q[XLEN-1:1]};
        else
          prod_q <= {{XLEN{1'b0}}, abs1_q} * {{XLEN{1'b0}}, abs2_q};
      end
    end
  end

  div_core #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .step      (step & op_q[2]),
    .dividend  (abs1_in),
    .divisor   (abs2_in),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // Remainders follow the dividend's sign; quotients and products the XOR of both.
  always_comb begin
    neg_res    = (op_q[2] & op_q[1]) ? sign1_q : (sign1_q ^ sign2_q);
    div_res    = op_q[1] ? remainder : quotient;
    div_fixed  = neg_res ? -div_res : div_res;
    prod_fixed = neg_res ? -prod_q : prod_q;
    if (op_q[2])            fix_data = div_fixed;
    else if (op_q == OP_MUL) fix_data = prod_fixed[XLEN-1:0];
    else                    fix_data = prod_fixed[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q     <= '0;
      rd_addr_out_q <= '0;
      rd_wen_q      <= 1'b0;
    end else begin
      rd_wen_q <= 1'b0;
      if (fast) begin
        rd_data_q     <= fast_data;
        rd_addr_out_q <= bus.rd_addr_i;
        rd_wen_q      <= 1'b1;
      end else if (fix) begin
        rd_data_q     <= fix_data;
        rd_addr_out_q <= rd_addr_q;
        rd_wen_q      <= 1'b1;
      end
    end
  end

  assign bus.hold_flag_o = ((state_q == ST_IDLE) & bus.start_i & ~bus.flush_i)
                         | (state_q == ST_CALC) | (state_q == ST_FIX);
  assign bus.busy_o      = (state_q != ST_IDLE);
  assign bus.rd_data_o   = rd_data_q;
  assign bus.rd_addr_o   = rd_addr_out_q;
  assign bus.rd_wen_o    = rd_wen_q;

endmodule
